result_monitor: RTL and testbench

- Receiving end of the operand driver. Takes the delayed operand pair from the driver, the DUT result and the measured DUT delay.
- Internally re-aligns the operands to the DUT output, recomputes the expected result and compares it every cycle.
- Counts checks and errors, captures the first mismatch and reports pass/fail to the board-level status logic.

---
 rtl/result_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_result_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_monitor.sv
// result_monitor: receiving end of the operand driver.
// Delays the driver's operand copy so that it lines up with the DUT output.
// Recomputes the expected result, compares it every cycle, counts checks and
// errors, and captures the first mismatch. The run result is reported as
// pass/fail.
//
// Ports:
//   clk_dut        sole clock
//   reset          synchronous, active-high
//   i_delayed_a/b  operands from the driver, already OPERAND_LAG cycles late
//   i_dut_out      DUT result
//   i_dut_delay    measured DUT latency (32'hFFFF = not yet measured)
//   o_busy         FILL or CHECK in progress
//   o_pass/o_fail  run outcome (o_fail also on range error)
//   o_range_err    measured delay cannot be aligned with the available taps
//   o_tap          latched alignment tap
//   o_check_count  comparisons performed
//   o_error_count  mismatches, saturating
//   o_first_err_*  operands, DUT result and expected value of the first mismatch
//
// Optional feature macro: RESULT_MONITOR_STOP_ON_ERR_EN
//   Defined  : the first mismatch ends the run immediately (DONE).
//   Undefined: the run always performs NUM_CHECKS comparisons.
//
// Parameter limits: WIDTH must be 32; MAX_TAP must be between 1 and 255.

module result_monitor #(
  parameter int WIDTH       = 32,
  parameter int OP          = 0,
  parameter int OPERAND_LAG = 2,
  parameter int MAX_TAP     = 15,
  parameter int NUM_CHECKS  = 1024
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_delayed_a,
  input  logic [WIDTH-1:0] i_delayed_b,
  input  logic [WIDTH-1:0] i_dut_out,
  input  logic [31:0]      i_dut_delay,
  output logic             o_busy,
  output logic             o_pass,
  output logic             o_fail,
  output logic             o_range_err,
  output logic [7:0]       o_tap,
  output logic [31:0]      o_check_count,
  output logic [15:0]      o_error_count,
  output logic [WIDTH-1:0] o_first_err_a,
  output logic [WIDTH-1:0] o_first_err_b,
  output logic [WIDTH-1:0] o_first_err_got,
  output logic [WIDTH-1:0] o_first_err_exp
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CHECK, S_DONE, S_RANGE} state_t;

  localparam logic [31:0] NOT_MEAS = 32'h0000_FFFF;
  localparam logic [31:0] LAG32    = 32'(OPERAND_LAG);
  localparam logic [31:0] MAXT32   = 32'(MAX_TAP);
  localparam logic [31:0] LAST_CHK = 32'(NUM_CHECKS - 1);

  state_t                           r_state, w_state_nxt;
  logic [MAX_TAP-1:0][WIDTH-1:0]    r_dly_a, r_dly_b;
  logic [7:0]                       r_tap, r_fill;
  logic [31:0]                      r_check_count;
  logic [15:0]                      r_error_count, w_err_nxt;
  logic [WIDTH-1:0]                 r_fe_a, r_fe_b, r_fe_got, r_fe_exp;
  logic                             r_busy, r_pass, r_fail, r_range_err;
  logic [WIDTH-1:0]                 w_a_tap, w_b_tap, w_exp;
  logic [31:0]                      w_k;
  logic                             w_range_bad, w_mismatch;

  assign w_k         = i_dut_delay - LAG32;
  assign w_range_bad = (i_dut_delay < LAG32) || (w_k > MAXT32);

  // Tap 0 is the live input; tap k selects the k-th register of the line.
  always_comb begin
    w_a_tap = i_delayed_a;
    w_b_tap = i_delayed_b;
    for (int i = 0; i < MAX_TAP; i++) begin
      if (r_tap == 8'(i + 1)) begin
        w_a_tap = r_dly_a[i];
        w_b_tap = r_dly_b[i];
      end
    end
  end

  // Reference result, wrapping modulo 2^WIDTH.
  always_comb begin
    if (OP == 1)      w_exp = w_a_tap - w_b_tap;
    else if (OP == 2) w_exp = w_a_tap * w_b_tap;
    else              w_exp = w_a_tap + w_b_tap;
  end

  assign w_mismatch = (i_dut_out != w_exp);

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_error_count;
    case (r_state)
      S_IDLE: begin
        if (i_dut_delay != NOT_MEAS)
          w_state_nxt = w_range_bad ? S_RANGE : S_FILL;
      end
      S_FILL: begin
        if (r_fill == 8'(MAX_TAP)) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_mismatch && (r_error_count != 16'hFFFF))
          w_err_nxt = r_error_count + 16'd1;
        if (r_check_count == LAST_CHK) w_state_nxt = S_DONE;
`ifdef RESULT_MONITOR_STOP_ON_ERR_EN
        if (w_mismatch) w_state_nxt = S_DONE;
`else
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_dut) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Alignment lines shift in every state; only reset clears them.
  always_ff @(posedge clk_dut) begin
    if (reset) begin
      r_dly_a <= '0;
      r_dly_b <= '0;
    end else begin
      r_dly_a[0] <= i_delayed_a;
      r_dly_b[0] <= i_delayed_b;
      for (int i = 1; i < MAX_TAP; i++) begin
        r_dly_a[i] <= r_dly_a[i-1];
        r_dly_b[i] <= r_dly_b[i-1];
      end
    end
  end

  always_ff @(posedge clk_dut) begin
    if (reset) begin
      r_tap         <= '0;
      r_fill        <= '0;
      r_check_count <= '0;
      r_error_count <= '0;
      r_fe_a        <= '0;
      r_fe_b        <= '0;
      r_fe_got      <= '0;
      r_fe_exp      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_fill <= '0;
          if (w_state_nxt == S_FILL) r_tap <= w_k[7:0];
        end
        S_FILL: r_fill <= r_fill + 8'd1;
        S_CHECK: begin
          r_check_count <= r_check_count + 32'd1;
          r_error_count <= w_err_nxt;
          // A zero error count marks this as the first mismatch.
          if (w_mismatch && (r_error_count == 16'd0)) begin
            r_fe_a   <= w_a_tap;
            r_fe_b   <= w_b_tap;
            r_fe_got <= i_dut_out;
            r_fe_exp <= w_exp;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags are registered from the next state, so they change on the
  // same edge as the state itself and never follow inputs combinationally.
  always_ff @(posedge clk_dut) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt == S_FILL) || (w_state_nxt == S_CHECK);
      r_pass      <= (w_state_nxt == S_DONE) && (w_err_nxt == 16'd0);
      r_fail      <= ((w_state_nxt == S_DONE) && (w_err_nxt != 16'd0)) ||
                     (w_state_nxt == S_RANGE);
      r_range_err <= (w_state_nxt == S_RANGE);
    end
  end

  assign o_busy          = r_busy;
  assign o_pass          = r_pass;
  assign o_fail          = r_fail;
  assign o_range_err     = r_range_err;
  assign o_tap           = r_tap;
  assign o_check_count   = r_check_count;
  assign o_error_count   = r_error_count;
  assign o_first_err_a   = r_fe_a;
  assign o_first_err_b   = r_fe_b;
  assign o_first_err_got = r_fe_got;
  assign o_first_err_exp = r_fe_exp;

endmodule

// File: tb/tb_result_monitor.sv
module tb_result_monitor;
  localparam int NCHK = 100;
  localparam int MAXT = 15;
  localparam int LAG  = 2;

  logic        clk_dut = 1'b0;
  logic        reset;
  logic [31:0] d_a, d_b, d_out, d_out_sub, d_delay;

  logic        busy, pass, fail, rerr;
  logic [7:0]  tap;
  logic [31:0] cc;
  logic [15:0] ec;
  logic [31:0] fa, fb, fg, fe;

  logic        s_busy, s_pass, s_fail, s_rerr;
  logic [7:0]  s_tap;
  logic [31:0] s_cc;
  logic [15:0] s_ec;
  logic [31:0] s_fa, s_fb, s_fg, s_fe;

  always #5 clk_dut = ~clk_dut;

  result_monitor #(.WIDTH(32), .OP(0), .OPERAND_LAG(LAG), .MAX_TAP(MAXT),
                   .NUM_CHECKS(NCHK)) u_add (
    .clk_dut(clk_dut), .reset(reset), .i_delayed_a(d_a), .i_delayed_b(d_b),
    .i_dut_out(d_out), .i_dut_delay(d_delay), .o_busy(busy), .o_pass(pass),
    .o_fail(fail), .o_range_err(rerr), .o_tap(tap), .o_check_count(cc),
    .o_error_count(ec), .o_first_err_a(fa), .o_first_err_b(fb),
    .o_first_err_got(fg), .o_first_err_exp(fe));

  result_monitor #(.WIDTH(32), .OP(1), .OPERAND_LAG(LAG), .MAX_TAP(MAXT),
                   .NUM_CHECKS(NCHK)) u_sub (
    .clk_dut(clk_dut), .reset(reset), .i_delayed_a(d_a), .i_delayed_b(d_b),
    .i_dut_out(d_out_sub), .i_dut_delay(d_delay), .o_busy(s_busy), .o_pass(s_pass),
    .o_fail(s_fail), .o_range_err(s_rerr), .o_tap(s_tap), .o_check_count(s_cc),
    .o_error_count(s_ec), .o_first_err_a(s_fa), .o_first_err_b(s_fb),
    .o_first_err_got(s_fg), .o_first_err_exp(s_fe));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Operand stream driven into the imaginary DUT, indexed by edge number
  // counted from the first edge after reset release.
  logic [31:0] xa [0:511];
  logic [31:0] xb [0:511];
  bit          corrupt [0:511];

  typedef struct {
    int unsigned delay;
    int          e1;      // check index carrying the first injected error, 0 = none
    int          e2;      // second injected error, 0 = none
    int          abort_at; // reset pulse at this check index, 0 = run to end
    int          exp_tap;
    bit          exp_range;
  } vec_t;

  // Runs one measurement with a monitor-level model of what the run must report.
  task automatic run_case(input vec_t v);
    int   len = MAXT + 1 + NCHK + 4;
    int   busy_cyc = 0;
    bit   both = 1'b0;
    bit   rng;
    int   d;
    int   first, nerr, exp_cc, exp_ec, nf;
    logic [31:0] av, bv, ea, eb, eexp, egot;

    rng = (v.delay < LAG) || ((v.delay - LAG) > MAXT);
    d   = int'(v.delay);
    for (int n = 0; n < 512; n++) begin
      xa[n] = $urandom;
      xb[n] = $urandom;
      corrupt[n] = 1'b0;
    end
    if (!rng) begin
      // Wrap-around operands at checks 30 and 31.
      xa[MAXT+1+30-d] = 32'hFFFF_FFFF; xb[MAXT+1+30-d] = 32'h1;
      xa[MAXT+1+31-d] = 32'h0;         xb[MAXT+1+31-d] = 32'h1;
      if (v.e1 > 0) begin
        xa[MAXT+1+v.e1-d] = 32'h3; xb[MAXT+1+v.e1-d] = 32'h4;
        corrupt[MAXT+1+v.e1] = 1'b1;
      end
      if (v.e2 > 0) corrupt[MAXT+1+v.e2] = 1'b1;
    end

    @(negedge clk_dut);
    reset = 1'b1; d_delay = v.delay;
    d_a = '0; d_b = '0; d_out = '0; d_out_sub = '0;
    @(posedge clk_dut);
    @(negedge clk_dut);
    reset = 1'b0;

    for (int n = 0; n < len; n++) begin
      if (v.abort_at > 0 && n == MAXT + 1 + v.abort_at) begin
        chk("cc_before_abort", cc, 32'(v.abort_at - 1));
        reset = 1'b1;
        @(posedge clk_dut);
        @(negedge clk_dut);
        reset = 1'b0;
        chk("abort_cc", cc, 32'd0);
        chk("abort_ec", 32'(ec), 32'd0);
        chk("abort_fa", fa, 32'd0);
        chk("abort_fg", fg, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tap", 32'(tap), 32'd0);
        return;
      end
      d_a = (n >= LAG) ? xa[n-LAG] : 32'd0;
      d_b = (n >= LAG) ? xb[n-LAG] : 32'd0;
      if (!rng && n >= d) begin
        av = xa[n-d]; bv = xb[n-d];
        d_out     = (av + bv) ^ {31'd0, corrupt[n]};
        d_out_sub = av - bv;
      end else begin
        d_out = '0; d_out_sub = '0;
      end
      if (n == 1) d_delay = 32'd9; // must be ignored once out of IDLE
      @(posedge clk_dut);
      @(negedge clk_dut);
      if (busy) busy_cyc++;
      if ((pass && fail) || (busy && (pass || fail))) both = 1'b1;
      if (n == 0) begin
        chk("tap", 32'(tap), 32'(v.exp_tap));
        chk("range_next_edge", 32'(rerr), 32'(v.exp_range));
      end
    end

    chk("pass_fail_exclusive", 32'(both), 32'd0);
    if (rng) begin
      chk("range_err", 32'(rerr), 32'd1);
      chk("range_fail", 32'(fail), 32'd1);
      chk("range_pass", 32'(pass), 32'd0);
      chk("range_cc", cc, 32'd0);
      chk("range_ec", 32'(ec), 32'd0);
      chk("range_busy_cycles", 32'(busy_cyc), 32'd0);
      return;
    end

    first = 0; nerr = 0;
    if (v.e1 > 0 && v.e1 <= NCHK) begin nerr++; first = v.e1; end
    if (v.e2 > 0 && v.e2 <= NCHK) begin
      nerr++;
      if (first == 0 || v.e2 < first) first = v.e2;
    end
`ifdef RESULT_MONITOR_STOP_ON_ERR_EN
    exp_cc = (first > 0) ? first : NCHK;
    exp_ec = (first > 0) ? 1 : 0;
`else
    exp_cc = NCHK;
    exp_ec = nerr;
`endif
    if (first > 0) begin
      nf   = MAXT + 1 + first;
      ea   = xa[nf-d]; eb = xb[nf-d];
      eexp = ea + eb;
      egot = eexp ^ 32'd1;
    end else begin
      ea = '0; eb = '0; eexp = '0; egot = '0;
    end
    chk("busy_cycles", 32'(busy_cyc), 32'(MAXT + 1 + exp_cc));
    chk("check_count", cc, 32'(exp_cc));
    chk("error_count", 32'(ec), 32'(exp_ec));
    chk("pass", 32'(pass), 32'(exp_ec == 0));
    chk("fail", 32'(fail), 32'(exp_ec != 0));
    chk("range_err_clear", 32'(rerr), 32'd0);
    chk("first_err_a", fa, ea);
    chk("first_err_b", fb, eb);
    chk("first_err_got", fg, egot);
    chk("first_err_exp", fe, eexp);
    chk("sub_pass", 32'(s_pass), 32'd1);
    chk("sub_check_count", s_cc, 32'(NCHK));
  endtask

  vec_t vecs [10];
  vec_t rv;

  function automatic int pick_err();
    int e;
    e = int'($urandom_range(1, NCHK));
    while (e == 30 || e == 31) e = int'($urandom_range(1, NCHK));
    return e;
  endfunction

  initial begin
    reset = 1'b1; d_delay = 32'h0000_FFFF;
    d_a = '0; d_b = '0; d_out = '0; d_out_sub = '0;

    vecs[0] = '{5,  0,  0,   0,  3, 1'b0};  // clean run
    vecs[1] = '{1,  0,  0,   0,  0, 1'b1};  // delay below lag
    vecs[2] = '{18, 0,  0,   0,  0, 1'b1};  // k = MAX_TAP+1
    vecs[3] = '{0,  0,  0,   0,  0, 1'b1};
    vecs[4] = '{17, 0,  0,   0, 15, 1'b0};  // deepest tap
    vecs[5] = '{2,  0,  0,   0,  0, 1'b0};  // combinational tap 0
    vecs[6] = '{5,  10, 0,   0,  3, 1'b0};  // 3+4 answered as 6
    vecs[7] = '{5,  7,  20,  0,  3, 1'b0};  // two errors
    vecs[8] = '{5,  5,  0,  40,  3, 1'b0};  // reset mid-CHECK
    vecs[9] = '{5,  0,  100, 0,  3, 1'b0};  // error on final check

    // Reset state.
    @(posedge clk_dut);
    @(negedge clk_dut);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pass_fail", 32'({pass, fail, rerr}), 32'd0);
    chk("reset_cc", cc, 32'd0);
    chk("reset_tap", 32'(tap), 32'd0);

    // Unmeasured delay keeps the monitor in IDLE.
    reset = 1'b0;
    repeat (12) @(negedge clk_dut);
    chk("idle_wait_busy", 32'(busy), 32'd0);
    chk("idle_wait_flags", 32'({pass, fail, rerr}), 32'd0);
    d_delay = 32'd5;
    @(negedge clk_dut);
    chk("idle_leave_busy", 32'(busy), 32'd1);
    chk("idle_leave_tap", 32'(tap), 32'd3);

    for (int i = 0; i < 10; i++) run_case(vecs[i]);
    // Full run after the aborted one.
    run_case(vecs[0]);

    for (int i = 0; i < 6; i++) begin
      rv.delay = $urandom_range(0, 19);
      rv.e1 = ($urandom_range(0, 2) == 0) ? 0 : pick_err();
      rv.e2 = ($urandom_range(0, 1) == 0) ? 0 : pick_err();
      if (rv.e2 == rv.e1) rv.e2 = 0;
      rv.abort_at = 0;
      rv.exp_range = (rv.delay < LAG) || ((rv.delay - LAG) > MAXT);
      rv.exp_tap = rv.exp_range ? 0 : int'(rv.delay) - LAG;
      run_case(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
